// File: rtl/laser_cover_scorer_if.sv
// rtl/laser_cover_scorer_if.sv - point stream, centre and score bundle for laser_cover_scorer
interface laser_cover_scorer_if #(
  parameter int CNT_W = 6
);
  logic             pt_valid;
  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       c1x;
  logic [3:0]       c1y;
  logic [3:0]       c2x;
  logic [3:0]       c2y;
  logic             done;
  logic [CNT_W-1:0] cov1;
  logic [CNT_W-1:0] cov2;
  logic [CNT_W-1:0] cov_union;
  logic             score_valid;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] best_union;
  logic             new_best;

  modport master (
    output pt_valid, x, y, c1x, c1y, c2x, c2y, done,
    input  cov1, cov2, cov_union, score_valid, busy, err, best_union, new_best
  );

  modport slave (
    input  pt_valid, x, y, c1x, c1y, c2x, c2y, done,
    output cov1, cov2, cov_union, score_valid, busy, err, best_union, new_best
  );
endinterface

// File: rtl/laser_cover_scorer.sv
// rtl/laser_cover_scorer.sv - radius-4 two-centre coverage scorer over a snooped point frame
// Optional best-union tracking is built when SCORE_BEST_EN is defined.
module laser_cover_scorer #(
  parameter int NUM_PTS = 40,
  parameter int CNT_W   = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  laser_cover_scorer_if.slave bus
);
  typedef enum logic [1:0] {LOAD, WAIT, SCAN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PTS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt, idx;
  logic [CNT_W-1:0] acc1, acc2, accu;
  logic [CNT_W-1:0] cov1_r, cov2_r, covu_r;
  logic [3:0]       c1x_r, c1y_r, c2x_r, c2y_r;
  logic             score_valid_r, err_r;
  logic [7:0]       pt_mem [NUM_PTS];
  logic [7:0]       pt;
  logic             in1, in2;
  logic [CNT_W-1:0] next1, next2, nextu;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Row per dx, bit per dy: set where dx*dx + dy*dy <= 16.
  function automatic logic inside_r4(input logic [3:0] dx, input logic [3:0] dy);
    logic [7:0] row;
    case (dx)
      4'd0:       row = 8'b0001_1111;
      4'd1, 4'd2: row = 8'b0000_1111;
      4'd3:       row = 8'b0000_0111;
      4'd4:       row = 8'b0000_0001;
      default:    row = 8'b0000_0000;
    endcase
    return (dy <= 4'd4) && row[dy[2:0]];
  endfunction

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.pt_valid)
      pt_mem[cnt] <= {bus.x, bus.y};
  end

  always_comb begin
    pt    = pt_mem[idx];
    in1   = inside_r4(abs_diff(pt[7:4], c1x_r), abs_diff(pt[3:0], c1y_r));
    in2   = inside_r4(abs_diff(pt[7:4], c2x_r), abs_diff(pt[3:0], c2y_r));
    next1 = acc1 + {{(CNT_W-1){1'b0}}, in1};
    next2 = acc2 + {{(CNT_W-1){1'b0}}, in2};
    nextu = accu + {{(CNT_W-1){1'b0}}, in1 | in2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      cnt           <= '0;
      idx           <= '0;
      acc1          <= '0;
      acc2          <= '0;
      accu          <= '0;
      cov1_r        <= '0;
      cov2_r        <= '0;
      covu_r        <= '0;
      c1x_r         <= '0;
      c1y_r         <= '0;
      c2x_r         <= '0;
      c2y_r         <= '0;
      score_valid_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      score_valid_r <= 1'b0;
      case (state)
        LOAD: begin
          if (bus.done)
            err_r <= 1'b1;
          if (bus.pt_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.done) begin
            c1x_r <= bus.c1x;
            c1y_r <= bus.c1y;
            c2x_r <= bus.c2x;
            c2y_r <= bus.c2y;
            acc1  <= '0;
            acc2  <= '0;
            accu  <= '0;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == LAST) begin
            cov1_r        <= next1;
            cov2_r        <= next2;
            covu_r        <= nextu;
            score_valid_r <= 1'b1;
            cnt           <= '0;
            state         <= LOAD;
          end else begin
            acc1 <= next1;
            acc2 <= next2;
            accu <= nextu;
            idx  <= idx + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef SCORE_BEST_EN
  logic [CNT_W-1:0] best_r;
  logic             new_best_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_r     <= '0;
      new_best_r <= 1'b0;
    end else begin
      new_best_r <= 1'b0;
      if (state == SCAN && idx == LAST && nextu > best_r) begin
        best_r     <= nextu;
        new_best_r <= 1'b1;
      end
    end
  end

  assign bus.best_union = best_r;
  assign bus.new_best   = new_best_r;
`else
  assign bus.best_union = '0;
  assign bus.new_best   = 1'b0;
`endif

  assign bus.cov1        = cov1_r;
  assign bus.cov2        = cov2_r;
  assign bus.cov_union   = covu_r;
  assign bus.score_valid = score_valid_r;
  assign bus.busy        = (state == SCAN);
  assign bus.err         = err_r;
endmodule

// File: tb/tb_laser_cover_scorer.sv
// tb/tb_laser_cover_scorer.sv - self-checking bench for laser_cover_scorer
module tb_laser_cover_scorer;
  localparam int NUM_PTS = 40;
  localparam int CNT_W   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  laser_cover_scorer_if #(.CNT_W(CNT_W)) bus();

  laser_cover_scorer #(.NUM_PTS(NUM_PTS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int px [NUM_PTS];
  int py [NUM_PTS];
  int best_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_circle(input int x, input int y, input int cx, input int cy);
    int dx, dy;
    dx = x - cx;
    dy = y - cy;
    return (dx * dx + dy * dy) <= 16;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cov1"}, 32'(bus.cov1), 0);
    check({tag, "_cov2"}, 32'(bus.cov2), 0);
    check({tag, "_covu"}, 32'(bus.cov_union), 0);
    check({tag, "_sv"}, 32'(bus.score_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_best"}, 32'(bus.best_union), 0);
    check({tag, "_newbest"}, 32'(bus.new_best), 0);
  endtask

  task automatic send_points(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      bus.pt_valid = 1'b1;
      bus.x = 4'(px[i]);
      bus.y = 4'(py[i]);
    end
    @(negedge clk);
    bus.pt_valid = 1'b0;
  endtask

  task automatic pulse_done(input int c1x, input int c1y, input int c2x, input int c2y);
    bus.done = 1'b1;
    bus.c1x = 4'(c1x);
    bus.c1y = 4'(c1y);
    bus.c2x = 4'(c2x);
    bus.c2y = 4'(c2y);
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic score_frame(input string tag, input int c1x, input int c1y,
                             input int c2x, input int c2y, input int exp_err);
    int e1, e2, eu, exp_nb, exp_best, k, busy_n;
    bit a, b;
    e1 = 0; e2 = 0; eu = 0;
    for (int i = 0; i < NUM_PTS; i++) begin
      a = in_circle(px[i], py[i], c1x, c1y);
      b = in_circle(px[i], py[i], c2x, c2y);
      e1 += int'(a);
      e2 += int'(b);
      eu += int'(a | b);
    end
`ifdef SCORE_BEST_EN
    exp_nb = (eu > best_model) ? 1 : 0;
    if (eu > best_model) best_model = eu;
    exp_best = best_model;
`else
    exp_nb = 0;
    exp_best = 0;
`endif
    pulse_done(c1x, c1y, c2x, c2y);
    check({tag, "_busy_start"}, 32'(bus.busy), 1);
    k = 0;
    busy_n = 1;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.score_valid === 1'b1) break;
      if (bus.busy === 1'b1) busy_n++;
    end
    check({tag, "_latency"}, 32'(k), 32'(NUM_PTS));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(NUM_PTS));
    check({tag, "_cov1"}, 32'(bus.cov1), 32'(e1));
    check({tag, "_cov2"}, 32'(bus.cov2), 32'(e2));
    check({tag, "_covu"}, 32'(bus.cov_union), 32'(eu));
    check({tag, "_newbest"}, 32'(bus.new_best), 32'(exp_nb));
    check({tag, "_best"}, 32'(bus.best_union), 32'(exp_best));
    check({tag, "_busy_end"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_sv_drop"}, 32'(bus.score_valid), 0);
    check({tag, "_nb_drop"}, 32'(bus.new_best), 0);
    check({tag, "_cov_hold"}, 32'(bus.cov_union), 32'(eu));
  endtask

  task automatic fill(input int n, input int ax, input int ay, input int bx, input int by);
    for (int i = 0; i < NUM_PTS; i++) begin
      px[i] = (i < n) ? ax : bx;
      py[i] = (i < n) ? ay : by;
    end
  endtask

  initial begin
    int unions [4];
    bus.pt_valid = 1'b0;
    bus.x = '0; bus.y = '0;
    bus.c1x = '0; bus.c1y = '0; bus.c2x = '0; bus.c2y = '0;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single centre
    fill(NUM_PTS, 8, 8, 8, 8);
    send_points(0, NUM_PTS);
    score_frame("single", 8, 8, 0, 0, 0);

    // Boundary points
    fill(0, 0, 15, 0, 15);
    px[0] = 12; py[0] = 8;
    px[1] = 8;  py[1] = 12;
    px[2] = 11; py[2] = 10;
    px[3] = 11; py[3] = 11;
    px[4] = 13; py[4] = 8;
    send_points(0, NUM_PTS);
    score_frame("boundary", 8, 8, 15, 0, 0);

    // Overlap
    fill(20, 5, 5, 7, 5);
    send_points(0, NUM_PTS);
    score_frame("overlap", 5, 5, 7, 5, 0);
    send_points(0, NUM_PTS);
    score_frame("overlap_far", 5, 5, 15, 15, 0);

    // Reset during scan
    fill(NUM_PTS, 8, 8, 8, 8);
    send_points(0, NUM_PTS);
    pulse_done(8, 8, 0, 0);
    repeat (20) @(negedge clk);
    check("midscan_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midscan_rst");
    best_model = 0;
    repeat (3) begin
      @(negedge clk);
      check("midscan_no_sv", 32'(bus.score_valid), 0);
    end
    rst_n = 1'b1;

    // Best-union sequence
    unions[0] = 12; unions[1] = 30; unions[2] = 30; unions[3] = 25;
    for (int f = 0; f < 4; f++) begin
      fill(unions[f], 8, 8, 0, 15);
      send_points(0, NUM_PTS);
      score_frame($sformatf("best%0d", f), 8, 8, 0, 0, 0);
    end

    // DONE coincident with the last point
    for (int i = 0; i < NUM_PTS; i++) begin
      px[i] = $urandom_range(0, 15);
      py[i] = $urandom_range(0, 15);
    end
    check("simul_err_pre", 32'(bus.err), 0);
    send_points(0, NUM_PTS - 1);
    bus.pt_valid = 1'b1;
    bus.x = 4'(px[NUM_PTS-1]);
    bus.y = 4'(py[NUM_PTS-1]);
    bus.done = 1'b1;
    @(negedge clk);
    bus.pt_valid = 1'b0;
    bus.done = 1'b0;
    check("simul_err", 32'(bus.err), 1);
    check("simul_not_scan", 32'(bus.busy), 0);
    @(negedge clk);
    check("simul_wait", 32'(bus.busy), 0);
    score_frame("simul", 4, 4, 10, 10, 1);

    // Early DONE in LOAD
    for (int i = 0; i < NUM_PTS; i++) begin
      px[i] = $urandom_range(2, 12);
      py[i] = $urandom_range(2, 12);
    end
    send_points(0, 10);
    pulse_done(7, 7, 3, 3);
    check("early_err", 32'(bus.err), 1);
    check("early_busy", 32'(bus.busy), 0);
    check("early_sv", 32'(bus.score_valid), 0);
    send_points(10, NUM_PTS);
    score_frame("early", 7, 7, 3, 3, 1);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NUM_PTS; i++) begin
        px[i] = $urandom_range(0, 15);
        py[i] = $urandom_range(0, 15);
      end
      send_points(0, NUM_PTS);
      score_frame($sformatf("rand%0d", f), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/laser_cover_scorer.md
Name: laser_cover_scorer

Overview:
- Downstream companion of the two-centre laser placement stage.
- Snoops the same 40-point X/Y input stream into a private buffer.
- Latches C1X/C1Y/C2X/C2Y when the placement stage pulses DONE, then scans the buffer one point per cycle.
- Reports per-centre and union coverage counts for radius-4 circles. Used for on-chip self-check and result scoring.

Parameters:
- NUM_PTS, 40, points per frame, buffer depth.
- CNT_W, 6, width of the index and count registers; must satisfy NUM_PTS < 2**CNT_W.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- PT_VALID  input  1  X/Y carry a valid point this cycle.
- X  input  4  point x coordinate.
- Y  input  4  point y coordinate.
- C1X, C1Y, C2X, C2Y  input  4 each  centres from the placement stage; sampled only on DONE.
- DONE  input  1  placement result valid, one-cycle pulse.
- COV1  output  CNT_W  points inside circle 1.
- COV2  output  CNT_W  points inside circle 2.
- COV_UNION  output  CNT_W  points inside circle 1 or circle 2.
- SCORE_VALID  output  1  one-cycle pulse; the COV outputs are updated in the same cycle.
- BUSY  output  1  high in SCAN.
- ERR  output  1  sticky protocol error.
- BEST_UNION  output  CNT_W  see Optional Feature.
- NEW_BEST  output  1  see Optional Feature.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, FSM to LOAD, load count 0, centre latches 0. Buffer contents need not be cleared.
- FSM states: LOAD, WAIT, SCAN.
- LOAD:
  - Each cycle with PT_VALID=1, write {X,Y} to buffer[cnt] and increment cnt.
  - Move to WAIT on the edge that stores the point with cnt==NUM_PTS-1.
  - A DONE seen in LOAD sets ERR and is otherwise ignored.
- WAIT:
  - PT_VALID is ignored.
  - On DONE=1, latch all four centre inputs, clear the accumulators and the scan index, and go to SCAN.
- SCAN: one point per edge, idx 0..NUM_PTS-1.
  - Per centre: dx = |px-cx| and dy = |py-cy|, each a 4-bit unsigned absolute difference with no wrap.
  - A point is inside if dx<=4, dy<=4 and dx²+dy²<=16. Use a 5x5 inside/outside table; do not use a multiplier.
  - Boundary distance 16 is inside, e.g. (4,0) and (0,4). (3,3)=18 is outside.
  - in1 increments COV1, in2 increments COV2, and (in1|in2) increments COV_UNION.
  - Duplicate points are each counted.
  - On the edge that processes idx NUM_PTS-1:
    - Register the final counts to COV1/COV2/COV_UNION.
    - Assert SCORE_VALID, clear cnt, and go to LOAD.
  - SCORE_VALID therefore rises exactly NUM_PTS cycles after the edge that sampled DONE, and drops on the following edge.
  - COV outputs hold until the next SCORE_VALID.
  - DONE and PT_VALID are ignored during SCAN. Points streamed during SCAN are not captured, and the upstream stage is required not to send them.
- BUSY = (state==SCAN).
- ERR is cleared only by reset. It never blocks normal operation.
- Simultaneous DONE and the last PT_VALID in LOAD: the point is stored, ERR is set, and the FSM goes to WAIT, not SCAN.
- Reset mid-SCAN: the scan is aborted, no SCORE_VALID is produced, and the block returns to the reset state.

Optional Feature:
- Macro SCORE_BEST_EN.
- Defined:
  - BEST_UNION holds the maximum COV_UNION seen since reset; it starts at 0.
  - NEW_BEST pulses together with SCORE_VALID when the new COV_UNION is strictly greater than BEST_UNION. BEST_UNION updates on that same edge.
  - A tie does not pulse NEW_BEST.
- Undefined: BEST_UNION and NEW_BEST are tied to 0 and no tracking logic is built. Ports are present in both builds.

Test Plan:
- Single centre: 40 points at (8,8), DONE with C1=(8,8), C2=(0,0) -> COV1=40, COV2=0, COV_UNION=40; SCORE_VALID exactly 40 cycles after DONE edge; BUSY high for 40 cycles.
- Boundary: points (12,8), (8,12), (11,10), (11,11), (13,8), plus 35×(0,15); C1=(8,8), C2=(15,0) -> COV1=3, COV2=0, COV_UNION=3.
- Overlap: 20×(5,5) and 20×(7,5), C1=(5,5), C2=(7,5) -> COV1=40, COV2=40, COV_UNION=40. Repeat with C2=(15,15) -> COV2=0, COV_UNION=40.
- Protocol error: DONE pulsed after 10 points -> ERR=1, no SCORE_VALID. Finish the 40 points and pulse DONE -> valid score produced, ERR remains 1.
- Reset mid-scan: RST_N low at scan idx 20 -> all outputs 0 immediately, no SCORE_VALID. The next full frame scores correctly.
- SCORE_BEST_EN: frames with union 12, 30, 30, 25 -> NEW_BEST pulses on frames 1 and 2 only; BEST_UNION ends at 30. Without the macro, both outputs stay 0.
